// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared encodings and bus widths for the IF/MEM memory arbiter.
package rv32i_mem_arbiter_pkg;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int DATA_BUS_W      = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;
endpackage

// File: rtl/rv32i_arb_pick.sv
// Winner selection between IF and MEM with a saturating starvation counter
// that forces IF through after STARVE_LIMIT consecutive MEM wins.
module rv32i_arb_pick
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic mem_req,
  output logic win_vld,
  output logic win_own
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // MEM has priority unless IF has been passed over LIMIT times in a row
  always_comb begin
    win_vld = arb_en & (if_req | mem_req);
    win_own = OWN_IF;
    if (mem_req && !(if_req && starve_cnt == LIMIT)) win_own = OWN_MEM;
  end

  // count MEM wins that overtook a waiting fetch; an IF win clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt <= '0;
    else if (win_vld) begin
      if (win_own == OWN_IF) starve_cnt <= '0;
      else if (if_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory bus shared between instruction fetch and load/store.
// IDLE/DONE arbitrate, ACCESS holds the latched request on the bus for
// WAIT_CYCLES cycles, DONE returns the sampled read data for one cycle.
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = INST_ADDR_BUS_W,
  parameter int DATA_W       = DATA_BUS_W,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_mode,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_ce,
  output logic              bus_we,
  output logic [3:0]        bus_mode,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  typedef struct packed {
    logic              we;
    logic [3:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0] state;
  logic       owner;
  logic [3:0] wait_cnt;
  logic       arb_en, win_vld, win_own;
  bus_req_t   win_req;

  assign arb_en = (state == IDLE) || (state == DONE);

  rv32i_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
    .if_req  (if_req),
    .mem_req (mem_req),
    .win_vld (win_vld),
    .win_own (win_own)
  );

  // winner's request fields; a fetch is always a full-word read
  always_comb begin
    win_req = '{we: 1'b0, mode: 4'hF, addr: if_addr, wdata: '0};
    if (win_own == OWN_MEM)
      win_req = '{we: mem_we, mode: mem_mode, addr: mem_addr, wdata: mem_wdata};
  end

  // main sequencer: bus fields, grant and completion pulses are all registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      wait_cnt   <= '0;
      bus_ce     <= 1'b0;
      bus_we     <= 1'b0;
      bus_mode   <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      if_gnt     <= 1'b0;
      mem_gnt    <= 1'b0;
      if_rvalid  <= 1'b0;
      mem_rvalid <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if_gnt     <= 1'b0;
      mem_gnt    <= 1'b0;
      if_rvalid  <= 1'b0;
      mem_rvalid <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      case (state)
        IDLE, DONE: begin
          if (win_vld) begin
            state     <= ACCESS;
            owner     <= win_own;
            wait_cnt  <= WAIT_LAST;
            bus_ce    <= 1'b1;
            bus_we    <= win_req.we;
            bus_mode  <= win_req.mode;
            bus_addr  <= win_req.addr;
            bus_wdata <= win_req.wdata;
            if_gnt    <= (win_own == OWN_IF);
            mem_gnt   <= (win_own == OWN_MEM);
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            state     <= DONE;
            bus_ce    <= 1'b0;
            bus_we    <= 1'b0;
            bus_mode  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if (owner == OWN_MEM) begin
              mem_rvalid <= 1'b1;
              mem_rdata  <= bus_we ? '0 : bus_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= bus_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_if  = if_req & ~if_rvalid;
  assign stall_mem = mem_req & ~mem_rvalid;
endmodule
